memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width; all requirements below are for DATA_WIDTH=32.
REQ-002 SHALL have parameter ADDRESS_BITS, default 20, byte-address width on the data-memory port.
REQ-003 SHALL have: clock input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have: reset input 1, asynchronous, active-high.
REQ-005 SHALL have: load, store inputs 1 each, access requests from execute stage.
REQ-006 SHALL have: funct3 input 3, access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have: ALU_result input DATA_WIDTH, effective byte address.
REQ-008 SHALL have: store_data input DATA_WIDTH, unshifted store operand.
REQ-009 SHALL have: load_data_memory output DATA_WIDTH, aligned and extended load result, feeding the memory/writeback pipe register.
REQ-010 SHALL have: stall_memory output 1, high while the access is incomplete; upstream holds all inputs stable while high.
REQ-011 SHALL have: access_fault output 1, misaligned or illegal access.
REQ-012 SHALL have: dmem_req output 1, dmem_we output 1, dmem_addr output ADDRESS_BITS, dmem_wdata output DATA_WIDTH, dmem_be output 4.
REQ-013 SHALL have: dmem_ready input 1 (request accepted), dmem_valid input 1 (read data valid), dmem_rdata input DATA_WIDTH (word-aligned read data).

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-015 SHALL treat an access as legal when exactly one of load/store is high, funct3 is legal for that type (store: 000/001/010), and the address is aligned (H: bit0=0; W: bits1:0=00).
REQ-016 SHALL, in IDLE with an illegal access, assert access_fault combinationally, keep stall_memory low, issue no request and stay in IDLE.
REQ-017 SHALL, in IDLE with a legal access, assert stall_memory combinationally and go to REQ.
REQ-018 SHALL, in REQ, drive dmem_req=1, dmem_addr=ALU_result[ADDRESS_BITS-1:0] with bits1:0 forced to 00, dmem_we=store; hold until dmem_ready=1.
REQ-019 SHALL, on dmem_ready in REQ, go to DONE for a store or WAIT for a load.
REQ-020 SHALL drive dmem_be: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; store bytes replicated into dmem_wdata (B: data[7:0] x4, H: data[15:0] x2, W: data).
REQ-021 SHALL, in WAIT, on dmem_valid register dmem_rdata and go to DONE; dmem_valid outside WAIT SHALL be ignored.
REQ-022 SHALL, in DONE, drive stall_memory=0 and return to IDLE next cycle; the request SHALL not restart in DONE.
REQ-023 SHALL form load_data_memory from the registered word: select byte/half by addr[1:0], sign-extend for B/H, zero-extend for BU/HU; value 0 for non-loads.
REQ-024 SHALL have stall_memory = (IDLE and legal access) or REQ or WAIT; dmem_req low in all states except REQ.
REQ-025 SHALL give minimum latency: store 2 stall cycles, load 3 stall cycles (dmem_ready, dmem_valid each one cycle after asserted need).

Reset
REQ-026 SHALL, on reset asserted (any state, asynchronously), go to IDLE, clear captured read data to 0, drop dmem_req immediately.
REQ-027 SHALL have reset output values: dmem_req=0, dmem_we=0, stall_memory=0, access_fault=0, load_data_memory=0.
REQ-028 SHALL abandon an in-flight access on reset mid-REQ/WAIT with no later dmem_valid effect.

Verification
REQ-029 SHALL cover: LW addr 0x100, ready+1, valid+1 rdata 0xDEADBEEF -> be 1111, stall 3 cycles, load_data 0xDEADBEEF in DONE.
REQ-030 SHALL cover: LB addr 0x103, rdata 0x80112233 -> be 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 SHALL cover: SH addr 0x102 data 0x0000ABCD -> dmem_we=1, be 1100, wdata 0xABCDABCD, stall 2 cycles, DONE then IDLE.
REQ-032 SHALL cover: LW addr 0x101 or load=store=1 -> access_fault=1, dmem_req never asserted, stall_memory=0.
REQ-033 SHALL cover: dmem_ready held low 5 cycles in REQ -> dmem_req and stall stay high; reset asserted in WAIT -> IDLE, outputs at reset values, late dmem_valid ignored.

Source files
------------

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - data-memory access unit: request/ready/valid handshake, byte lanes, load alignment
module memory_access_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    store,
    input  logic [2:0]              funct3,
    input  logic [DATA_WIDTH-1:0]   ALU_result,
    input  logic [DATA_WIDTH-1:0]   store_data,
    output logic [DATA_WIDTH-1:0]   load_data_memory,
    output logic                    stall_memory,
    output logic                    access_fault,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDRESS_BITS-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [3:0]              dmem_be,
    input  logic                    dmem_ready,
    input  logic                    dmem_valid,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [1:0]              byte_off;
    logic                    size_b;
    logic                    size_h;
    logic                    size_w;
    logic                    load_f3_ok;
    logic                    store_f3_ok;
    logic                    aligned;
    logic                    legal;
    logic                    capture;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;

    // Address bits above the memory port width never reach the memory.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^ALU_result[DATA_WIDTH-1:ADDRESS_BITS];

    assign byte_off = ALU_result[1:0];

    // Access decode: size, funct3 legality per access type, alignment.
    always_comb begin
        size_b      = (funct3[1:0] == 2'b00);
        size_h      = (funct3[1:0] == 2'b01);
        size_w      = (funct3[1:0] == 2'b10);
        load_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        store_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        aligned     = size_b || (size_h && !byte_off[0]) || (size_w && (byte_off == 2'b00));
        legal       = (load ^ store) && (load ? load_f3_ok : store_f3_ok) && aligned;
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; stall/fault are forced low while reset is held.
    always_comb begin
        state_next   = state;
        stall_memory = 1'b0;
        access_fault = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (legal) begin
                    stall_memory = 1'b1;
                    state_next   = REQ;
                end else if (load || store) begin
                    access_fault = 1'b1;
                end
            end
            REQ: begin
                stall_memory = 1'b1;
                dmem_req     = 1'b1;
                dmem_we      = store;
                if (dmem_ready) begin
                    state_next = store ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_memory = 1'b1;
                if (dmem_valid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            stall_memory = 1'b0;
            access_fault = 1'b0;
            dmem_req     = 1'b0;
            dmem_we      = 1'b0;
        end
    end

    // Read word is captured only when the memory answers in WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= dmem_rdata;
        end
    end

    // Memory-side address, byte enables and replicated store data.
    always_comb begin
        dmem_addr = {ALU_result[ADDRESS_BITS-1:2], 2'b00};
        case (funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << byte_off;
                dmem_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << byte_off;
                dmem_wdata = {2{store_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = store_data;
            end
        endcase
    end

    // Load result: pick the addressed byte/half from the captured word and extend it.
    always_comb begin
        byte_sel = rdata_q[{byte_off, 3'b000} +: 8];
        half_sel = rdata_q[{byte_off[1], 4'b0000} +: 16];
        load_data_memory = '0;
        if (load) begin
            case (funct3)
                3'b000:  load_data_memory = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
                3'b001:  load_data_memory = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                3'b010:  load_data_memory = rdata_q;
                3'b100:  load_data_memory = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
                3'b101:  load_data_memory = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                default: load_data_memory = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - self-checking bench for memory_access_unit
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] ALU_result;
    logic [31:0] store_data;
    logic [31:0] load_data_memory;
    logic        stall_memory;
    logic        access_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [19:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    memory_access_unit dut (
        .clock            (clock),
        .reset            (reset),
        .load             (load),
        .store            (store),
        .funct3           (funct3),
        .ALU_result       (ALU_result),
        .store_data       (store_data),
        .load_data_memory (load_data_memory),
        .stall_memory     (stall_memory),
        .access_fault     (access_fault),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_ready       (dmem_ready),
        .dmem_valid       (dmem_valid),
        .dmem_rdata       (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes.
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int s;
        logic [31:0] ones;
        s    = size_of(f3);
        ones = (32'd1 << s) - 32'd1;
        if (s == 4) return ones;
        return ones << addr[1:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int s;
        s = size_of(f3);
        if (s == 1) return (d & 32'hFF) * 32'h01010101;
        if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic is_load, input logic [2:0] f3,
                                           input logic [31:0] addr, input logic [31:0] rd);
        int s;
        logic [31:0] mask;
        logic [31:0] v;
        if (!is_load) return 32'd0;
        s    = size_of(f3);
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v    = (rd >> (8 * addr[1:0])) & mask;
        if (s < 4 && !f3[2] && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    // One full access driven with a responsive memory; rdly/vdly extra wait cycles.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rd, input int rdly, input int vdly);
        int stalls;
        int reqc;
        int waitc;
        int phase;
        bit done;
        logic [31:0] exp_addr;
        stalls   = 0;
        reqc     = 0;
        waitc    = 0;
        phase    = 0;
        done     = 1'b0;
        exp_addr = {12'd0, addr[19:2], 2'b00};
        @(posedge clock);
        #1;
        load = ld; store = st; funct3 = f3; ALU_result = addr; store_data = sd;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clock);
            dmem_ready = 1'b0;
            dmem_valid = 1'b0;
            if (stall_memory) stalls++;
            if (dmem_req) begin
                phase = 1;
                reqc++;
                check("req_addr", {12'd0, dmem_addr}, exp_addr);
                check("req_we", {31'd0, dmem_we}, {31'd0, st});
                check("req_be", {28'd0, dmem_be}, m_be(f3, addr));
                if (st) check("req_wdata", dmem_wdata, m_wdata(f3, sd));
                dmem_ready = (reqc > rdly);
                dmem_valid = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end else if (stall_memory && phase == 1) begin
                waitc++;
                dmem_valid = (waitc > vdly);
                dmem_rdata = (waitc > vdly) ? rd : $urandom;
            end else if (stall_memory) begin
                dmem_valid = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end else begin
                done = 1'b1;
                check("done_after_req", phase, 1);
                check("load_data", load_data_memory, m_load(ld, f3, addr, rd));
                check("stall_cycles", stalls, st ? 2 + rdly : 3 + rdly + vdly);
                check("done_fault", {31'd0, access_fault}, 0);
            end
        end
        if (!done) check("access_timeout", 0, 1);
        @(posedge clock);
        #1;
        check("no_restart", {31'd0, dmem_req}, 0);
        load = 1'b0; store = 1'b0; dmem_valid = 1'b0; dmem_ready = 1'b0;
    endtask

    // Illegal access: fault visible, no stall, no request for several cycles.
    task automatic fault_case(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr);
        @(posedge clock);
        #1;
        load = ld; store = st; funct3 = f3; ALU_result = addr; store_data = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            dmem_ready = 1'b1;
            check("fault_flag", {31'd0, access_fault}, 1);
            check("fault_stall", {31'd0, stall_memory}, 0);
            check("fault_req", {31'd0, dmem_req}, 0);
        end
        dmem_ready = 1'b0;
        load = 1'b0; store = 1'b0;
    endtask

    initial begin
        int op;
        logic [2:0]  rf3;
        logic        rst_;
        logic [31:0] raddr;
        reset = 1'b1;
        load = 1'b1; store = 1'b0; funct3 = 3'b010; ALU_result = 32'h100; store_data = 32'd0;
        dmem_ready = 1'b0; dmem_valid = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req", {31'd0, dmem_req}, 0);
        check("rst_we", {31'd0, dmem_we}, 0);
        check("rst_stall", {31'd0, stall_memory}, 0);
        check("rst_fault", {31'd0, access_fault}, 0);
        check("rst_load_data", load_data_memory, 0);
        load = 1'b0;
        reset = 1'b0;

        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80112233, 0, 0);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80112233, 0, 0);
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'd0, 0, 0);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h8001_7FFF, 1, 2);

        fault_case(1'b1, 1'b0, 3'b010, 32'h101);
        fault_case(1'b1, 1'b1, 3'b010, 32'h100);
        fault_case(1'b0, 1'b1, 3'b010, 32'h102);
        fault_case(1'b0, 1'b1, 3'b100, 32'h100);
        fault_case(1'b1, 1'b0, 3'b101, 32'h1);

        run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'h1234_5678, 5, 0);
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'hA5, 32'd0, 5, 0);

        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: begin rst_ = 1'b1; rf3 = 3'b000; end
                1: begin rst_ = 1'b1; rf3 = 3'b001; end
                2: begin rst_ = 1'b1; rf3 = 3'b010; end
                3: begin rst_ = 1'b1; rf3 = 3'b100; end
                4: begin rst_ = 1'b1; rf3 = 3'b101; end
                5: begin rst_ = 1'b0; rf3 = 3'b000; end
                6: begin rst_ = 1'b0; rf3 = 3'b001; end
                default: begin rst_ = 1'b0; rf3 = 3'b010; end
            endcase
            raddr = $urandom;
            if (size_of(rf3) == 2) raddr[0] = 1'b0;
            if (size_of(rf3) == 4) raddr[1:0] = 2'b00;
            run_access(rst_, !rst_, rf3, raddr, $urandom, $urandom,
                       $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset while waiting for read data, then stray valids afterwards.
        @(posedge clock);
        #1;
        load = 1'b1; store = 1'b0; funct3 = 3'b010; ALU_result = 32'h300;
        @(negedge clock);
        dmem_ready = 1'b1;
        @(negedge clock);
        check("mid_req", {31'd0, dmem_req}, 1);
        @(negedge clock);
        dmem_ready = 1'b0;
        check("in_wait_stall", {31'd0, stall_memory}, 1);
        check("in_wait_req", {31'd0, dmem_req}, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_req", {31'd0, dmem_req}, 0);
        check("arst_stall", {31'd0, stall_memory}, 0);
        check("arst_we", {31'd0, dmem_we}, 0);
        check("arst_fault", {31'd0, access_fault}, 0);
        check("arst_load_data", load_data_memory, 0);
        @(negedge clock);
        reset = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dmem_valid = 1'b1;
            dmem_rdata = 32'hCAFE_F00D;
            @(negedge clock);
            check("late_valid_stall", {31'd0, stall_memory}, 0);
            check("late_valid_req", {31'd0, dmem_req}, 0);
        end
        dmem_valid = 1'b0;
        load = 1'b1;
        #1;
        check("late_valid_ignored", load_data_memory, 0);
        check("idle_legal_stall", {31'd0, stall_memory}, 1);
        load = 1'b0;
        @(negedge clock);
        check("final_idle", {31'd0, stall_memory}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
